// File: rtl/cordic_wave_osc.sv
// ---------------------------------------------------------------------------
// cordic_wave_osc
//
// Purpose:
//   Phase-accumulator waveform oscillator. Each accepted start request
//   produces one output sample. Sine comes from an iterative CORDIC rotation
//   (one micro-rotation per clock). Square, saw and triangle are derived
//   directly from the sampled phase. All modes take the same latency.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request one sample; sampled only while idle
//   mode       in   2'b00 sine, 01 square, 10 saw, 11 triangle
//   freq_inc   in   phase increment, added to the accumulator after each sample
//   phase_off  in   phase offset (full circle = 2^OUT_BITS)
//   phase_clr  in   synchronous accumulator clear (wins over the increment)
//   gain       in   amplitude gain, (gain+1)/16 (only with the macro below)
//   busy       out  high while a sample is in progress
//   valid      out  one-cycle pulse when out updates
//   out        out  offset-binary sample, midscale = 2^(OUT_BITS-1)
//
// Build option:
//   CORDIC_WAVE_AMP_SCALE_EN - adds the gain input and scales every waveform
//   about midscale before it is loaded into out.
//
// Timing: start sampled at edge E0, ITER rotation edges, then the DONE edge
// loads out and pulses valid (valid high ITER+1 cycles after E0).
// ---------------------------------------------------------------------------
module cordic_wave_osc #(
  parameter int ACC_BITS = 16,
  parameter int OUT_BITS = 8,
  parameter int ITER     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ACC_BITS-4:0] freq_inc,
  input  logic [OUT_BITS-1:0] phase_off,
  input  logic                phase_clr,
`ifdef CORDIC_WAVE_AMP_SCALE_EN
  input  logic [3:0]          gain,
`endif
  output logic                busy,
  output logic                valid,
  output logic [OUT_BITS-1:0] out
);

  // Phase / CORDIC word width: two guard bits below the output resolution.
  localparam int W   = OUT_BITS + 2;
  localparam int IW  = $clog2(ITER + 1);
  localparam int MID = 1 << (OUT_BITS - 1);
  localparam int AMP = MID - 1;
  // Start vector pre-scaled by the CORDIC gain 1/K (39797/65536 ~ 0.6073).
  localparam int X0  = (AMP * 39797) >> 16;

  localparam logic signed [W-1:0] AMP_POS = W'(AMP);
  localparam logic signed [W-1:0] AMP_NEG = -W'(AMP);
  localparam logic [W-1:0]        HALF    = W'(1) << (W - 1);
  localparam logic [OUT_BITS-1:0] MID_O   = OUT_BITS'(MID);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // arctan(2^-i) with a full circle of 2^16.
  function automatic logic [15:0] atan16(input logic [IW-1:0] i);
    case (i)
      IW'(0):  atan16 = 16'd8192;
      IW'(1):  atan16 = 16'd4836;
      IW'(2):  atan16 = 16'd2555;
      IW'(3):  atan16 = 16'd1297;
      IW'(4):  atan16 = 16'd651;
      IW'(5):  atan16 = 16'd326;
      IW'(6):  atan16 = 16'd163;
      IW'(7):  atan16 = 16'd81;
      IW'(8):  atan16 = 16'd41;
      IW'(9):  atan16 = 16'd20;
      IW'(10): atan16 = 16'd10;
      IW'(11): atan16 = 16'd5;
      IW'(12): atan16 = 16'd3;
      IW'(13): atan16 = 16'd1;
      IW'(14): atan16 = 16'd1;
      default: atan16 = 16'd0;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [IW-1:0]        iter_q, iter_d;
  logic signed [W-1:0]  x_q, x_d;
  logic signed [W-1:0]  y_q, y_d;
  logic signed [W-1:0]  z_q, z_d;
  logic [ACC_BITS-1:0]  acc_q, acc_d;
  logic [ACC_BITS-4:0]  freq_q, freq_d;
  logic [1:0]           mode_q, mode_d;
  // Phase bits [W-1:1]; bit 0 only matters for the sine fold at E0.
  logic [W-2:0]         p_q, p_d;
  logic [OUT_BITS-1:0]  out_q, out_d;
  logic                 valid_q, valid_d;
`ifdef CORDIC_WAVE_AMP_SCALE_EN
  logic [3:0]           gain_q, gain_d;
`endif

  logic [W-1:0]         phase_now;
  logic [W-1:0]         z_fold;
  logic signed [W-1:0]  atan_i;
  logic signed [W-1:0]  y_clamp;
  logic [OUT_BITS-1:0]  wave_v;
  logic [OUT_BITS-1:0]  out_val;

  // Sampled phase: top W accumulator bits plus the offset scaled to W bits.
  assign phase_now = acc_q[ACC_BITS-1 -: W] + {phase_off, 2'b00};
  assign atan_i    = W'(atan16(iter_q) >> (16 - W));

  // Fold quadrants 2 and 3 onto [-90, +90] degrees where CORDIC converges;
  // sin(180 - p) = sin(p) so y needs no correction afterwards.
  always_comb begin
    z_fold = phase_now;
    if (phase_now[W-1] ^ phase_now[W-2]) begin
      z_fold = HALF - phase_now;
    end
  end

  always_comb begin
    y_clamp = y_q;
    if (y_q > AMP_POS) begin
      y_clamp = AMP_POS;
    end else if (y_q < AMP_NEG) begin
      y_clamp = AMP_NEG;
    end
  end

  always_comb begin
    wave_v = '0;
    case (mode_q)
      2'b00:   wave_v = OUT_BITS'(y_clamp + W'(MID));
      2'b01:   wave_v = p_q[W-2] ? '0 : '1;
      2'b10:   wave_v = p_q[W-2:1];
      default: wave_v = p_q[W-2] ? ~p_q[W-3:0] : p_q[W-3:0];
    endcase
  end

`ifdef CORDIC_WAVE_AMP_SCALE_EN
  // Scale about midscale: s * (gain+1) / 16, arithmetic shift keeps sign.
  logic signed [OUT_BITS:0]   s_v;
  logic [5:0]                 g_v;
  logic signed [OUT_BITS+6:0] prod_v;
  logic signed [OUT_BITS+6:0] scaled_v;

  always_comb begin
    s_v      = $signed({1'b0, wave_v}) - $signed({1'b0, MID_O});
    g_v      = {2'b00, gain_q} + 6'd1;
    prod_v   = $signed({{6{s_v[OUT_BITS]}}, s_v}) *
               $signed({{(OUT_BITS + 1){1'b0}}, g_v});
    scaled_v = prod_v >>> 4;
    out_val  = OUT_BITS'(scaled_v) + MID_O;
  end
`else
  assign out_val = wave_v;
`endif

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    acc_d   = acc_q;
    freq_d  = freq_q;
    mode_d  = mode_q;
    p_d     = p_q;
    out_d   = out_q;
    valid_d = 1'b0;
`ifdef CORDIC_WAVE_AMP_SCALE_EN
    gain_d  = gain_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          freq_d  = freq_inc;
          p_d     = phase_now[W-1:1];
          x_d     = W'(X0);
          y_d     = '0;
          z_d     = z_fold;
          iter_d  = '0;
          state_d = S_RUN;
`ifdef CORDIC_WAVE_AMP_SCALE_EN
          gain_d  = gain;
`endif
        end
      end
      S_RUN: begin
        if (!z_q[W-1]) begin
          x_d = x_q - (y_q >>> iter_q);
          y_d = y_q + (x_q >>> iter_q);
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + (y_q >>> iter_q);
          y_d = y_q - (x_q >>> iter_q);
          z_d = z_q + atan_i;
        end
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(ITER - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_d   = out_val;
        valid_d = 1'b1;
        acc_d   = acc_q + ACC_BITS'(freq_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear wins over the DONE increment but leaves the sample running.
    if (phase_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      freq_q  <= '0;
      mode_q  <= '0;
      p_q     <= '0;
      out_q   <= MID_O;
      valid_q <= 1'b0;
`ifdef CORDIC_WAVE_AMP_SCALE_EN
      gain_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef CORDIC_WAVE_AMP_SCALE_EN
      gain_q  <= gain_d;
`endif
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign valid = valid_q;
  assign out   = out_q;

endmodule

// File: tb/tb_cordic_wave_osc.sv
// ---------------------------------------------------------------------------
// tb_cordic_wave_osc
//
// Directed testbench for cordic_wave_osc at ACC_BITS=16, OUT_BITS=8, ITER=8.
// The accumulator is observed indirectly through saw samples taken with
// freq_inc=0 and phase_off=0 (out = acc[15:8]).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cordic_wave_osc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [12:0] freq_inc;
  logic [7:0]  phase_off;
  logic        phase_clr;
`ifdef CORDIC_WAVE_AMP_SCALE_EN
  logic [3:0]  gain;
`endif
  logic        busy;
  logic        valid;
  logic [7:0]  out;

  int checks;
  int failures;

  cordic_wave_osc #(
    .ACC_BITS(16),
    .OUT_BITS(8),
    .ITER(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .freq_inc (freq_inc),
    .phase_off(phase_off),
    .phase_clr(phase_clr),
`ifdef CORDIC_WAVE_AMP_SCALE_EN
    .gain     (gain),
`endif
    .busy     (busy),
    .valid    (valid),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  // One full sample; returns out and cycles from the start edge to valid.
  task automatic run_sample(input logic [1:0] m, input logic [12:0] fi,
                            input logic [7:0] po, output int res, output int lat);
    @(negedge clk);
    mode = m; freq_inc = fi; phase_off = po; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    res = int'(out);
  endtask

  task automatic clear_acc();
    @(negedge clk);
    phase_clr = 1'b1;
    @(posedge clk); #1;
    phase_clr = 1'b0;
  endtask

  function automatic int in_range(input int v, input int lo, input int hi);
    return (v >= lo && v <= hi) ? 1 : 0;
  endfunction

  initial begin
    int res, lat, nvalid;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; freq_inc = '0;
    phase_off = '0; phase_clr = 1'b0;
`ifdef CORDIC_WAVE_AMP_SCALE_EN
    gain = 4'd15;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out", int'(out), 128);
    check_eq("reset_valid", int'(valid), 0);
    check_eq("reset_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;

    // First sine sample at acc=0, plus latency and busy during the run.
    @(negedge clk);
    mode = 2'b00; freq_inc = 13'h1000; phase_off = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", int'(busy), 1);
    lat = 0;
    while (!valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("sine0_latency", lat, 9);
    check_eq($sformatf("sine0_out%0d_in126..130", out), in_range(int'(out), 126, 130), 1);
    @(posedge clk); #1;
    check_eq("valid_one_cycle", int'(valid), 0);
    run_sample(2'b10, 13'h0, 8'h00, res, lat);
    check_eq("acc_eq_freq_inc", res, 16);

    // Sine sweep in 22.5 degree steps from acc=0.
    clear_acc();
    for (int k = 0; k <= 12; k++) begin
      run_sample(2'b00, 13'h1000, 8'h00, res, lat);
      if (k == 4)  check_eq($sformatf("sine90_out%0d_in250..255", res),  in_range(res, 250, 255), 1);
      if (k == 8)  check_eq($sformatf("sine180_out%0d_in126..130", res), in_range(res, 126, 130), 1);
      if (k == 12) check_eq($sformatf("sine270_out%0d_in0..5", res),     in_range(res, 0, 5), 1);
    end

    // Square / saw / triangle at 0, 90 and 180 degrees.
    clear_acc();
    run_sample(2'b01, 13'h0, 8'h00, res, lat);
    check_eq("square_acc0", res, 255);
    check_eq("square_latency", lat, 9);
    for (int k = 0; k < 4; k++) begin
      run_sample(2'b10, 13'h1000, 8'h00, res, lat);
      check_eq($sformatf("saw_step%0d", k), res, 16 * k);
    end
    run_sample(2'b10, 13'h0, 8'h00, res, lat);
    check_eq("saw_acc4000", res, 64);
    run_sample(2'b11, 13'h0, 8'h00, res, lat);
    check_eq("tri_acc4000", res, 128);
    check_eq("tri_latency", lat, 9);
    for (int k = 0; k < 4; k++) begin
      run_sample(2'b10, 13'h1000, 8'h00, res, lat);
      check_eq($sformatf("saw_step%0d", k + 4), res, 64 + 16 * k);
    end
    run_sample(2'b01, 13'h0, 8'h00, res, lat);
    check_eq("square_acc8000", res, 0);
    run_sample(2'b11, 13'h0, 8'h00, res, lat);
    check_eq("tri_acc8000", res, 255);

    // Phase offset of a quarter circle.
    clear_acc();
    run_sample(2'b00, 13'h0, 8'h40, res, lat);
    check_eq($sformatf("sine_off90_out%0d_in250..255", res), in_range(res, 250, 255), 1);

    // phase_clr on the DONE edge beats the increment.
    @(negedge clk);
    mode = 2'b00; freq_inc = 13'h1000; phase_off = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); phase_clr = 1'b1;
    @(posedge clk); #1;
    phase_clr = 1'b0;
    check_eq("clr_done_valid", int'(valid), 1);
    run_sample(2'b10, 13'h0, 8'h00, res, lat);
    check_eq("clr_beats_inc", res, 0);

    // start held through a whole run, inputs changing mid-run.
    @(negedge clk);
    mode = 2'b10; freq_inc = 13'h0; phase_off = 8'h00; start = 1'b1;
    @(posedge clk);
    nvalid = 0; res = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c <= 9); mode = 2'b01; phase_off = 8'h40;
      @(posedge clk); #1;
      if (valid) begin
        nvalid++;
        res = int'(out);
      end
    end
    check_eq("start_ignored_valids", nvalid, 1);
    check_eq("latched_inputs_saw", res, 0);
    check_eq("no_queued_start_busy", int'(busy), 0);
    phase_off = 8'h00;

    // Reset in the middle of a run.
    run_sample(2'b10, 13'h1000, 8'h00, res, lat);
    run_sample(2'b10, 13'h0, 8'h00, res, lat);
    check_eq("pre_reset_acc", res, 16);
    @(negedge clk);
    mode = 2'b00; freq_inc = 13'h1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_eq("midrun_rst_out", int'(out), 128);
    check_eq("midrun_rst_valid", int'(valid), 0);
    check_eq("midrun_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    check_eq("midrun_rst_no_valid", nvalid, 0);
    run_sample(2'b10, 13'h0, 8'h00, res, lat);
    check_eq("midrun_rst_acc0", res, 0);

`ifdef CORDIC_WAVE_AMP_SCALE_EN
    clear_acc();
    gain = 4'd7;
    run_sample(2'b01, 13'h0, 8'h00, res, lat);
    check_eq("gain7_square", res, 191);
    gain = 4'd15;
    run_sample(2'b01, 13'h0, 8'h00, res, lat);
    check_eq("gain15_square", res, 255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
